spi_slave: RTL
==============

Name: spi_slave

Overview:
- SPI responder (target) for the 32-bit SPI link driven by the team's SPI master.
- Receives MOSI frames into a parallel word and returns a preloaded word on MISO.
- Sits on the peripheral side of the MPSoC interconnect; the host core loads reply data and consumes received words.
- All SPI pins are asynchronous to the system clock and are oversampled through synchronizers.

Parameters:
DATA_W, 32, frame length in bits; also width of tx_data/rx_data. MSB first.

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-high
spi_clk  input  1  SPI serial clock from master, CPOL=0
spi_mosi  input  1  serial data from master
spi_cs  input  1  chip select from master, active-low
spi_miso  output  1  serial data to master
tx_data  input  DATA_W  reply word for next frame
tx_load  input  1  1-cycle strobe: capture tx_data into reply buffer
rx_data  output  DATA_W  last complete received word
rx_valid  output  1  1-cycle pulse: rx_data updated
busy  output  1  frame in progress (synchronized CS low)
frame_err  output  1  1-cycle pulse: CS deasserted mid-frame
tx_underrun  output  1  1-cycle pulse: frame started with no fresh tx_load since previous frame start

Behaviour:
- Single clock (clk); reset synchronous, active-high.
- Reset values: spi_miso=0, rx_data=0, rx_valid=0, busy=0, frame_err=0, tx_underrun=0. Internal state: tx_buf=0, tx_fresh=0, bit_cnt=0, state IDLE. Synchronizers reset so that sync CS=1 and sync SCK=0.
- Input sync: spi_clk, spi_mosi and spi_cs each pass through a 2-FF synchronizer.
  - Edge detect compares the synced value with a 3rd register.
  - Pin-to-internal-event latency: 3 clk.
- Timing requirement: each SCK high and low phase is at least 4 clk. Mode 0: master drives MOSI on SCK falling edge and samples MISO on SCK rising edge.
- tx_load: tx_buf<=tx_data, tx_fresh<=1. Accepted in any state.
- State IDLE (sync CS high):
  - spi_miso=0, busy=0.
  - On CS falling event: go to ACTIVE, bit_cnt<=0, tx_shift<=tx_buf, and set busy=1 from the next cycle.
  - If tx_load occurs in the same cycle as the CS falling event: tx_shift<=tx_data (bypass), and no underrun.
  - Otherwise, if tx_fresh=0: pulse tx_underrun (the stale tx_buf is retransmitted).
  - tx_fresh<=0 in either case.
- State ACTIVE:
  - spi_miso = tx_shift[DATA_W-1] at all times.
  - SCK rising: rx_shift<={rx_shift[DATA_W-2:0], sync MOSI}, bit_cnt<=bit_cnt+1.
  - SCK falling: tx_shift<=tx_shift<<1, unless reload_pend=1. If reload_pend=1: tx_shift<=tx_buf, reload_pend<=0, and the underrun/fresh rule applies as at frame start.
  - Word complete (rising edge with bit_cnt==DATA_W-1):
    - Next cycle: rx_data<={rx_shift[DATA_W-2:0], bit}, rx_valid=1 for exactly 1 clk.
    - bit_cnt<=0 and reload_pend<=1. Back-to-back frames under one CS are supported.
  - CS rising event:
    - Go to IDLE, bit_cnt<=0, reload_pend<=0, rx_data unchanged.
    - If bit_cnt!=0, pulse frame_err (partial word discarded, no rx_valid).
    - If a word completed in the same cycle, rx_valid still fires.
- rx_valid has no back-pressure. A consumer that misses the pulse loses the word; rx_data holds until the next completion.
- rst asserted mid-frame: immediate return to reset values. The frame is lost. A new frame requires a CS high→low transition after reset release.
- SCK edges while CS is high are ignored.

Test Plan:
- Reset then idle: rst high 3 clk → all outputs 0, busy=0; SCK toggles with CS high → no rx_valid, spi_miso stays 0.
- Full duplex: tx_load with tx_data=0xA5A5_0F0F, then master sends 0xDEAD_BEEF (SCK phase 5 clk) → one rx_valid pulse, rx_data=0xDEADBEEF; master captures 0xA5A50F0F; tx_underrun=0.
- Back-to-back: CS held low for 64 SCK cycles sending 0x1234_5678 then 0x9ABC_DEF0, with tx_load 0x1111_1111 before the frame and 0x2222_2222 between words → two rx_valid pulses with the correct words; MISO returns 0x11111111 then 0x22222222.
- Abort: CS raised after 10 bits → frame_err pulse, no rx_valid, rx_data keeps its prior value; the next full frame is received correctly.
- Underrun: two frames with a single tx_load of 0x0000_00FF → second frame pulses tx_underrun and MISO repeats 0x000000FF.
- Mid-frame reset: rst pulsed at bit 16 → outputs return to 0, busy=0, no rx_valid; the next CS-framed 0xCAFE_F00D is received intact.

Source files
------------

// File: rtl/spi_slave.sv
// SPI responder (CPOL=0, mode 0) for the 32-bit SPI link.
// SPI pins are oversampled on clk through 2-FF synchronizers. A third register
// per pin gives edge detection, so a pin change becomes an internal event 3 clk later.
// Received words appear on rx_data with a one-cycle rx_valid pulse.
// The reply word is loaded with tx_load and is shifted out MSB first on spi_miso.
module spi_slave #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_clk,
  input  logic              spi_mosi,
  input  logic              spi_cs,
  output logic              spi_miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              frame_err,
  output logic              tx_underrun
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  // Synchronizer chains: [0] first stage, [1] synced value, [2] previous synced value.
  logic [2:0] sck_q;
  logic [2:0] cs_q;
  logic [1:0] mosi_q;
  // After reset, CS must be seen high before a falling edge can open a frame.
  logic [1:0] fill_q;
  logic       arm_q;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] tx_buf_q, tx_buf_d;
  logic              tx_fresh_q, tx_fresh_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic              reload_pend_q, reload_pend_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              tx_underrun_q, tx_underrun_d;

  logic sck_rise_s, sck_fall_s, cs_fall_s, cs_rise_s, mosi_s;
  logic reload_s, word_done_s;

  assign sck_rise_s  = sck_q[1] & ~sck_q[2];
  assign sck_fall_s  = ~sck_q[1] & sck_q[2];
  assign cs_fall_s   = ~cs_q[1] & cs_q[2] & arm_q;
  assign cs_rise_s   = cs_q[1] & ~cs_q[2];
  assign mosi_s      = mosi_q[1];
  assign word_done_s = sck_rise_s & (bit_cnt_q == LAST_BIT);

  // The reply shifter is (re)loaded at frame start, or on the first SCK fall after a completed word.
  // A CS rise in the same cycle wins over that fall, so a frame ending with SCK and CS moving together does not consume the reply buffer.
  assign reload_s = ((state_q == ST_IDLE) & cs_fall_s) |
                    ((state_q == ST_ACTIVE) & sck_fall_s & ~cs_rise_s & reload_pend_q);

  // Pin synchronizers, edge-history registers and the post-reset CS arming flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_q  <= 3'b000;
      cs_q   <= 3'b111;
      mosi_q <= 2'b00;
      fill_q <= 2'd0;
      arm_q  <= 1'b0;
    end else begin
      sck_q  <= {sck_q[1:0], spi_clk};
      cs_q   <= {cs_q[1:0], spi_cs};
      mosi_q <= {mosi_q[0], spi_mosi};
      fill_q <= (fill_q == 2'd2) ? fill_q : fill_q + 2'd1;
      arm_q  <= arm_q | ((fill_q == 2'd2) & cs_q[1]);
    end
  end

  // Frame state and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      bit_cnt_q     <= '0;
      tx_buf_q      <= '0;
      tx_fresh_q    <= 1'b0;
      tx_shift_q    <= '0;
      rx_shift_q    <= '0;
      reload_pend_q <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      tx_buf_q      <= tx_buf_d;
      tx_fresh_q    <= tx_fresh_d;
      tx_shift_q    <= tx_shift_d;
      rx_shift_q    <= rx_shift_d;
      reload_pend_q <= reload_pend_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      frame_err_q   <= frame_err_d;
      tx_underrun_q <= tx_underrun_d;
    end
  end

  // Next-state logic: frame open/close, bit shifting, word completion and reply reload.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    tx_buf_d      = tx_buf_q;
    tx_fresh_d    = tx_fresh_q;
    tx_shift_d    = tx_shift_q;
    rx_shift_d    = rx_shift_q;
    reload_pend_d = reload_pend_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    frame_err_d   = 1'b0;
    tx_underrun_d = 1'b0;

    if (tx_load) begin
      tx_buf_d   = tx_data;
      tx_fresh_d = 1'b1;
    end else begin
      tx_buf_d = tx_buf_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (cs_fall_s) begin
          state_d       = ST_ACTIVE;
          bit_cnt_d     = '0;
          reload_pend_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (sck_rise_s) begin
          rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s};
          if (word_done_s) begin
            rx_data_d     = {rx_shift_q[DATA_W-2:0], mosi_s};
            rx_valid_d    = 1'b1;
            bit_cnt_d     = '0;
            reload_pend_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end else if (sck_fall_s && !cs_rise_s) begin
          if (reload_pend_q) begin
            reload_pend_d = 1'b0;
          end else begin
            tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
          end
        end else begin
          tx_shift_d = tx_shift_q;
        end
        if (cs_rise_s) begin
          state_d       = ST_IDLE;
          bit_cnt_d     = '0;
          reload_pend_d = 1'b0;
          // Partial word: count is non-zero after this cycle's edge (if any) is applied.
          frame_err_d   = sck_rise_s ? (bit_cnt_q != LAST_BIT) : (bit_cnt_q != '0);
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A tx_load coinciding with the reload bypasses the buffer and counts as fresh.
    if (reload_s) begin
      tx_fresh_d = 1'b0;
      if (tx_load) begin
        tx_shift_d = tx_data;
      end else begin
        tx_shift_d    = tx_buf_q;
        tx_underrun_d = ~tx_fresh_q;
      end
    end else begin
      tx_fresh_d = tx_fresh_d;
    end
  end

  assign spi_miso    = (state_q == ST_ACTIVE) ? tx_shift_q[DATA_W-1] : 1'b0;
  assign busy        = (state_q == ST_ACTIVE);
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_err   = frame_err_q;
  assign tx_underrun = tx_underrun_q;

endmodule
